// File: rtl/vend_credit_ctrl.sv
// Vending-machine credit controller: accumulates coins, checks a selection
// against a per-item price table, issues a vend request and pays change back
// one CHANGE_UNIT per cycle.
module vend_credit_ctrl #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned N_ITEMS     = 4,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd75, 8'd50, 8'd35, 8'd25},
    parameter int unsigned MAX_CREDIT  = 100,
    parameter int unsigned CHANGE_UNIT = 5,
    localparam int unsigned IDX_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                vend_valid,
    output logic [IDX_W-1:0]    vend_idx,
    output logic                change_pulse,
    output logic                busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t                r_state;
    logic [CREDIT_W-1:0]   r_credit;
    logic                  r_coin_reject;
    logic                  r_sel_err;
    logic                  r_vend_valid;
    logic [IDX_W-1:0]      r_vend_idx;
    logic                  r_change_pulse;
    logic                  r_busy;

    state_t                w_state;
    logic [CREDIT_W-1:0]   w_credit;
    logic                  w_coin_reject;
    logic                  w_sel_err;
    logic                  w_vend_valid;
    logic [IDX_W-1:0]      w_vend_idx;
    logic                  w_change_pulse;
    logic                  w_busy;

    logic [CREDIT_W-1:0]   w_price;
    logic                  w_idx_ok;
    logic [SUM_W-1:0]      w_coin_sum;
    logic                  w_coin_ok;

    // Price lookup for the selected item; flags indices beyond the table
    always_comb begin
        w_price  = '0;
        w_idx_ok = 1'b0;
        for (int i = 0; i < int'(N_ITEMS); i++) begin
            if (IDX_W'(i) == sel_idx) begin
                w_price  = PRICES[i*CREDIT_W +: CREDIT_W];
                w_idx_ok = 1'b1;
            end
        end
    end

    // Coin acceptance: non-zero, whole change units, and the unwrapped sum fits
    always_comb begin
        w_coin_sum = {1'b0, r_credit} + {1'b0, coin_value};
        w_coin_ok  = (coin_value != '0)
                  && ((coin_value % CREDIT_W'(CHANGE_UNIT)) == '0)
                  && (w_coin_sum <= SUM_W'(MAX_CREDIT));
    end

    // Next-state and next-output decode
    always_comb begin
        w_state        = r_state;
        w_credit       = r_credit;
        w_coin_reject  = 1'b0;
        w_sel_err      = 1'b0;
        w_vend_valid   = r_vend_valid;
        w_vend_idx     = r_vend_idx;
        w_change_pulse = 1'b0;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                if (cancel) begin
                    // A coin in the same cycle as a refund request is handed back
                    w_coin_reject = coin_valid;
                    if (r_state == S_CREDIT) begin
                        w_state = S_CHANGE;
                    end
                end else if (sel_valid) begin
                    w_coin_reject = coin_valid;
                    if ((r_state == S_IDLE) || !w_idx_ok || (r_credit < w_price)) begin
                        w_sel_err = 1'b1;
                    end else begin
                        w_credit     = r_credit - w_price;
                        w_vend_valid = 1'b1;
                        w_vend_idx   = sel_idx;
                        w_state      = S_VEND;
                    end
                end else if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_credit = w_coin_sum[CREDIT_W-1:0];
                        w_state  = S_CREDIT;
                    end else begin
                        w_coin_reject = 1'b1;
                    end
                end
            end

            S_VEND: begin
                w_coin_reject = coin_valid;
                w_sel_err     = sel_valid;
                if (vend_ack) begin
                    w_vend_valid = 1'b0;
                    w_state      = (r_credit != '0) ? S_CHANGE : S_IDLE;
                end
            end

            S_CHANGE: begin
                w_coin_reject = coin_valid;
                w_sel_err     = sel_valid;
                // Last unit clamps to zero so credit can never wrap below it
                if (r_credit > CREDIT_W'(CHANGE_UNIT)) begin
                    w_credit       = r_credit - CREDIT_W'(CHANGE_UNIT);
                    w_change_pulse = 1'b1;
                end else if (r_credit != '0) begin
                    w_credit       = '0;
                    w_change_pulse = 1'b1;
                    w_state        = S_IDLE;
                end else begin
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state == S_VEND) || (w_state == S_CHANGE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_coin_reject  <= 1'b0;
            r_sel_err      <= 1'b0;
            r_vend_valid   <= 1'b0;
            r_vend_idx     <= '0;
            r_change_pulse <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_credit       <= w_credit;
            r_coin_reject  <= w_coin_reject;
            r_sel_err      <= w_sel_err;
            r_vend_valid   <= w_vend_valid;
            r_vend_idx     <= w_vend_idx;
            r_change_pulse <= w_change_pulse;
            r_busy         <= w_busy;
        end
    end

    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign sel_err      = r_sel_err;
    assign vend_valid   = r_vend_valid;
    assign vend_idx     = r_vend_idx;
    assign change_pulse = r_change_pulse;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: the stimulus process pushes the
// reference model's expected outputs; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_idx = '0;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_err;
    logic       vend_valid;
    logic [1:0] vend_idx;
    logic       change_pulse;
    logic       busy;

    typedef struct packed {
        logic [7:0] credit;
        logic       coin_reject;
        logic       sel_err;
        logic       vend_valid;
        logic [1:0] vend_idx;
        logic       change_pulse;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_push = 0;
    int n_pop = 0;

    // Reference model: plain credit arithmetic plus "vending"/"refunding" flags
    int price_tab[4] = '{25, 35, 50, 75};
    int coin_tab[10] = '{5, 10, 25, 50, 7, 0, 100, 3, 250, 255};
    int m_credit = 0;
    bit m_vend = 1'b0;
    bit m_refund = 1'b0;
    int m_idx = 0;

    vend_credit_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .cancel       (cancel),
        .vend_ack     (vend_ack),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err),
        .vend_valid   (vend_valid),
        .vend_idx     (vend_idx),
        .change_pulse (change_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model_step(input bit cv, input int cval, input bit sv,
                                        input int sidx, input bit cc, input bit ack);
        exp_t e;
        bit rej = 1'b0;
        bit err = 1'b0;
        bit pulse = 1'b0;
        if (m_refund) begin
            rej = cv;
            err = sv;
            if (m_credit > 0) begin
                m_credit -= 5;
                pulse = 1'b1;
            end
            if (m_credit == 0) m_refund = 1'b0;
        end else if (m_vend) begin
            rej = cv;
            err = sv;
            if (ack) begin
                m_vend = 1'b0;
                m_refund = (m_credit > 0);
            end
        end else if (cc) begin
            rej = cv;
            m_refund = (m_credit > 0);
        end else if (sv) begin
            rej = cv;
            if (m_credit == 0 || sidx >= 4 || m_credit < price_tab[sidx]) begin
                err = 1'b1;
            end else begin
                m_credit -= price_tab[sidx];
                m_vend = 1'b1;
                m_idx = sidx;
            end
        end else if (cv) begin
            if (cval != 0 && cval % 5 == 0 && m_credit + cval <= 100) m_credit += cval;
            else rej = 1'b1;
        end
        e.credit       = 8'(m_credit);
        e.coin_reject  = rej;
        e.sel_err      = err;
        e.vend_valid   = m_vend;
        e.vend_idx     = 2'(m_idx);
        e.change_pulse = pulse;
        e.busy         = m_vend | m_refund;
        return e;
    endfunction

    // One clock of stimulus; the expected result for the following edge is queued
    task automatic cyc(input bit cv, input int cval, input bit sv, input int sidx,
                       input bit cc, input bit ack);
        exp_t e;
        @(negedge clk);
        coin_valid = cv;
        coin_value = 8'(cval);
        sel_valid  = sv;
        sel_idx    = 2'(sidx);
        cancel     = cc;
        vend_ack   = ack;
        e = model_step(cv, cval, sv, sidx, cc, ack);
        q.push_back(e);
        n_push++;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic coin(input int v);
        cyc(1'b1, v, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Idle cycles while counting change pulses
    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            idle_cyc();
            settle();
            if (change_pulse === 1'b1) pulses++;
        end
    endtask

    // Async reset asserted between edges; outputs must clear without a clock
    task automatic reset_check(input string name);
        @(negedge clk);
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; vend_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check({name, " credit"}, 32'(credit), 32'd0);
        check({name, " flags"}, 32'({coin_reject, sel_err, vend_valid, change_pulse, busy}), 32'd0);
        m_credit = 0; m_vend = 1'b0; m_refund = 1'b0; m_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle
    always begin
        exp_t e;
        exp_t a;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_pop++;
            a.credit       = credit;
            a.coin_reject  = coin_reject;
            a.sel_err      = sel_err;
            a.vend_valid   = vend_valid;
            a.vend_idx     = vend_idx;
            a.change_pulse = change_pulse;
            a.busy         = busy;
            if (!e.vend_valid) begin
                a.vend_idx = '0;
                e.vend_idx = '0;
            end
            check("cycle outputs {credit,rej,err,vv,idx,pulse,busy}", 32'(a), 32'(e));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of accumulating credit
        coin(25); coin(10); coin(5);
        settle();
        check("t1 credit before reset", 32'(credit), 32'd40);
        reset_check("t1 reset");

        // Vend item 1 (price 35) from 50, then 15 back as three pulses
        coin(25); coin(25);
        cyc(1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        settle();
        check("t2 credit after vend", 32'(credit), 32'd15);
        check("t2 vend_valid/idx", 32'({vend_valid, vend_idx}), 32'({1'b1, 2'd1}));
        idle_cyc();
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        count_pulses(5, p);
        check("t2 change pulses", 32'(p), 32'd3);
        check("t2 idle after change", 32'({busy, credit}), 32'd0);

        // Full credit, overflow coin, odd coin in IDLE
        repeat (4) coin(25);
        coin(5);
        settle();
        check("t3 overflow reject", 32'({coin_reject, credit}), 32'({1'b1, 8'd100}));
        cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        count_pulses(22, p);
        check("t3 refund pulses", 32'(p), 32'd20);
        coin(7);
        settle();
        check("t3 coin 7 reject", 32'({coin_reject, credit}), 32'({1'b1, 8'd0}));

        // Insufficient credit, then cancel refunds everything
        coin(25); coin(25);
        cyc(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
        settle();
        check("t4 sel_err", 32'({sel_err, busy, credit}), 32'({1'b1, 1'b0, 8'd50}));
        cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        count_pulses(12, p);
        check("t4 refund pulses", 32'(p), 32'd10);

        // Exact-price vend with a competing coin that must be refused
        coin(25);
        cyc(1'b1, 10, 1'b1, 0, 1'b0, 1'b0);
        settle();
        check("t5 vend exact", 32'({vend_valid, vend_idx, coin_reject, credit}),
              32'({1'b1, 2'd0, 1'b1, 8'd0}));
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        count_pulses(3, p);
        check("t5 no change pulses", 32'({p[7:0], busy}), 32'd0);

        // Coin whose sum would wrap in CREDIT_W bits
        coin(10);
        coin(250);
        settle();
        check("wrap coin reject", 32'({coin_reject, credit}), 32'({1'b1, 8'd10}));
        reset_check("wrap reset");

        // Reset during change after one pulse
        coin(10); coin(5);
        cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        idle_cyc();
        settle();
        check("t6 first pulse", 32'({change_pulse, credit}), 32'({1'b1, 8'd10}));
        reset_check("t6 reset");

        // Randomised traffic against the model, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_check("random reset");
            end else begin
                cyc($urandom_range(0, 99) < 40, coin_tab[$urandom_range(0, 9)],
                    $urandom_range(0, 99) < 12, int'($urandom_range(0, 3)),
                    $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 35);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(n_pop), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
